// File: rtl/sfsm_pkg.sv
// Shared types and helpers for the sfsm configuration front end.
// FSM state encoding, default word width and an odd-parity check.
package sfsm_pkg;

  localparam int unsigned DefaultDataW = 32;
  // Widest frame the parity helper accepts; narrower frames are zero-padded.
  localparam int unsigned MaxFrameW    = 256;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StCheck,
    StHold
  } sfsm_state_e;

  // Zero padding does not change the XOR, so any frame up to MaxFrameW fits.
  function automatic logic odd_parity_ok(input logic [MaxFrameW-1:0] bits);
    return ^bits;
  endfunction

endpackage

// File: rtl/sfsm_cfg_loader.sv
// Serial configuration loader: shifts a framed word in on din, checks it, and
// hands it to the sfsm core over valid/ready. SFSM_CFG_PARITY_EN adds an odd-parity bit.
module sfsm_cfg_loader
  import sfsm_pkg::*;
#(
  parameter int unsigned DATA_W = DefaultDataW
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              load_en,
  input  logic              din,
  input  logic              cfg_ready,
  output logic [DATA_W-1:0] cfg_data,
  output logic              cfg_valid,
  output logic              busy,
  output logic              dout,
  output logic              frame_err
);

`ifdef SFSM_CFG_PARITY_EN
  localparam int unsigned FRAME_BITS = DATA_W + 1;
`else
  localparam int unsigned FRAME_BITS = DATA_W;
`endif
  localparam int unsigned CNT_W = $clog2(FRAME_BITS + 1);

  sfsm_state_e           state_q;
  logic [FRAME_BITS-1:0] shift_q;
  logic [FRAME_BITS-1:0] shift_in;
  logic [CNT_W-1:0]      count_q;
  logic                  load_en_q;
  logic                  frame_start;

  assign shift_in    = {shift_q[FRAME_BITS-2:0], din};
  assign frame_start = load_en && !load_en_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      shift_q   <= '0;
      count_q   <= '0;
      // Starts high so a window already open at reset release is not a frame.
      load_en_q <= 1'b1;
      cfg_data  <= '0;
      cfg_valid <= 1'b0;
      busy      <= 1'b0;
      dout      <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      load_en_q <= load_en;
      dout      <= shift_q[FRAME_BITS-1];
      unique case (state_q)
        StIdle: begin
          if (frame_start) begin
            shift_q   <= shift_in;
            count_q   <= CNT_W'(1);
            frame_err <= 1'b0;
            busy      <= 1'b1;
            state_q   <= StShift;
          end
        end
        StShift: begin
          if (load_en) begin
            shift_q <= shift_in;
            count_q <= count_q + CNT_W'(1);
            if (count_q == CNT_W'(FRAME_BITS - 1)) begin
              state_q <= StCheck;
            end
          end else begin
            frame_err <= 1'b1;
            busy      <= 1'b0;
            state_q   <= StIdle;
          end
        end
        StCheck: begin
          if (load_en) begin
            frame_err <= 1'b1;
            busy      <= 1'b0;
            state_q   <= StIdle;
`ifdef SFSM_CFG_PARITY_EN
          end else if (!odd_parity_ok(MaxFrameW'(shift_q))) begin
            frame_err <= 1'b1;
            busy      <= 1'b0;
            state_q   <= StIdle;
          end else begin
            cfg_data  <= shift_q[FRAME_BITS-1:1];
            cfg_valid <= 1'b1;
            state_q   <= StHold;
          end
`else
          end else begin
            cfg_data  <= shift_q;
            cfg_valid <= 1'b1;
            state_q   <= StHold;
          end
`endif
        end
        StHold: begin
          if (cfg_ready) begin
            cfg_valid <= 1'b0;
            busy      <= 1'b0;
            state_q   <= StIdle;
          end
        end
        default: begin
          busy    <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sfsm_cfg_loader.sv
// Directed bench for sfsm_cfg_loader; builds with or without SFSM_CFG_PARITY_EN.
module tb_sfsm_cfg_loader;

  localparam int unsigned DATA_W = 32;
`ifdef SFSM_CFG_PARITY_EN
  localparam int FB = 33;
`else
  localparam int FB = 32;
`endif

  logic              clk;
  logic              reset_n;
  logic              load_en;
  logic              din;
  logic              cfg_ready;
  logic [DATA_W-1:0] cfg_data;
  logic              cfg_valid;
  logic              busy;
  logic              dout;
  logic              frame_err;

  int n_chk  = 0;
  int n_fail = 0;

  sfsm_cfg_loader #(.DATA_W(DATA_W)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .load_en   (load_en),
    .din       (din),
    .cfg_ready (cfg_ready),
    .cfg_data  (cfg_data),
    .cfg_valid (cfg_valid),
    .busy      (busy),
    .dout      (dout),
    .frame_err (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives the low n bits of 'bits' MSB first, one per clock, with load_en high.
  task automatic send(input logic [63:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      load_en = 1'b1;
      din     = bits[i];
      step();
    end
  endtask

  function automatic logic [63:0] frame_of(input logic [31:0] d);
`ifdef SFSM_CFG_PARITY_EN
    return {31'd0, d, ~^d};
`else
    return {32'd0, d};
`endif
  endfunction

  initial begin
    reset_n   = 1'b0;
    load_en   = 1'b0;
    din       = 1'b0;
    cfg_ready = 1'b0;
    #12;
    chk("rst_valid", 64'(cfg_valid), 64'd0);
    chk("rst_data", 64'(cfg_data), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_dout", 64'(dout), 64'd0);
    chk("rst_err", 64'(frame_err), 64'd0);
    reset_n = 1'b1;
    step();

    // Good frame, accepted immediately.
    cfg_ready = 1'b1;
`ifdef SFSM_CFG_PARITY_EN
    send({31'd0, 32'hA5A5_0F0F, 1'b1}, FB);
`else
    send({32'd0, 32'hA5A5_0F0F}, FB);
`endif
    chk("t1_busy_check", 64'(busy), 64'd1);
    chk("t1_valid_check", 64'(cfg_valid), 64'd0);
    load_en = 1'b0;
    step();
    chk("t1_valid", 64'(cfg_valid), 64'd1);
    chk("t1_data", 64'(cfg_data), 64'hA5A5_0F0F);
    chk("t1_err", 64'(frame_err), 64'd0);
    chk("t1_busy_hold", 64'(busy), 64'd1);
    step();
    chk("t1_valid_drop", 64'(cfg_valid), 64'd0);
    chk("t1_busy_drop", 64'(busy), 64'd0);

`ifdef SFSM_CFG_PARITY_EN
    // Bad parity keeps the previous word.
    send({31'd0, 32'hA5A5_0F0F, 1'b0}, FB);
    load_en = 1'b0;
    step();
    chk("t2_err", 64'(frame_err), 64'd1);
    chk("t2_valid", 64'(cfg_valid), 64'd0);
    chk("t2_data", 64'(cfg_data), 64'hA5A5_0F0F);
    chk("t2_busy", 64'(busy), 64'd0);
    load_en = 1'b1;
    din     = 1'b0;
    step();
    chk("t2_err_clr", 64'(frame_err), 64'd0);
    chk("t2_busy_start", 64'(busy), 64'd1);
    load_en = 1'b0;
    step();
    chk("t2_short1", 64'(frame_err), 64'd1);
`endif

    // Short frame.
    send(64'hF_FFFF, 20);
    chk("t3_short_busy", 64'(busy), 64'd1);
    chk("t3_short_errclr", 64'(frame_err), 64'd0);
    load_en = 1'b0;
    step();
    chk("t3_short_err", 64'(frame_err), 64'd1);
    chk("t3_short_idle", 64'(busy), 64'd0);
    chk("t3_short_valid", 64'(cfg_valid), 64'd0);

    // Overlong frame, then no restart while load_en stays high.
    send(frame_of(32'h0F0F_0F0F), FB);
    load_en = 1'b1;
    din     = 1'b0;
    step();
    chk("t3_long_err", 64'(frame_err), 64'd1);
    chk("t3_long_busy", 64'(busy), 64'd0);
    chk("t3_long_valid", 64'(cfg_valid), 64'd0);
    chk("t3_long_data", 64'(cfg_data), 64'hA5A5_0F0F);
    step();
    step();
    step();
    chk("t3_no_restart", 64'(busy), 64'd0);
    load_en = 1'b0;
    step();
    load_en = 1'b1;
    step();
    chk("t3_restart", 64'(busy), 64'd1);
    load_en = 1'b0;
    step();
    chk("t3_restart_abort", 64'(frame_err), 64'd1);

    // Backpressure with a load_en pulse during HOLD.
    cfg_ready = 1'b0;
    send(frame_of(32'h1234_5678), FB);
    load_en = 1'b0;
    step();
    chk("t4_valid", 64'(cfg_valid), 64'd1);
    chk("t4_data", 64'(cfg_data), 64'h1234_5678);
    chk("t4_err", 64'(frame_err), 64'd0);
    for (int i = 0; i < 5; i++) begin
      load_en = (i == 1);
      step();
      chk("t4_hold_valid", 64'(cfg_valid), 64'd1);
      chk("t4_hold_data", 64'(cfg_data), 64'h1234_5678);
      chk("t4_hold_busy", 64'(busy), 64'd1);
      chk("t4_hold_err", 64'(frame_err), 64'd0);
    end
    load_en   = 1'b0;
    cfg_ready = 1'b1;
    step();
    chk("t4_accept_valid", 64'(cfg_valid), 64'd0);
    chk("t4_accept_busy", 64'(busy), 64'd0);
    chk("t4_accept_data", 64'(cfg_data), 64'h1234_5678);

    // Reset mid-shift with load_en held through release.
    send(64'h3FF, 10);
    chk("t5_busy_pre", 64'(busy), 64'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("t5_rst_data", 64'(cfg_data), 64'd0);
    chk("t5_rst_busy", 64'(busy), 64'd0);
    chk("t5_rst_valid", 64'(cfg_valid), 64'd0);
    chk("t5_rst_err", 64'(frame_err), 64'd0);
    chk("t5_rst_dout", 64'(dout), 64'd0);
    step();
    step();
    #3 reset_n = 1'b1;
    step();
    step();
    chk("t5_no_start", 64'(busy), 64'd0);
    load_en = 1'b0;
    step();
    load_en = 1'b1;
    din     = 1'b0;
    step();
    chk("t5_start", 64'(busy), 64'd1);
    load_en = 1'b0;
    step();
    chk("t5_abort", 64'(frame_err), 64'd1);

    // Serial echo: a lone 1 reaches dout one edge after it reaches the MSB.
    cfg_ready = 1'b1;
    send(64'd1 << (FB - 1), FB);
    chk("t6_dout_lag", 64'(dout), 64'd0);
    load_en = 1'b0;
    step();
    chk("t6_dout", 64'(dout), 64'd1);
    chk("t6_valid", 64'(cfg_valid), 64'd1);
    chk("t6_data", 64'(cfg_data), 64'h8000_0000);
    step();
    chk("t6_valid_drop", 64'(cfg_valid), 64'd0);

`ifndef SFSM_CFG_PARITY_EN
    send(64'h1, FB);
    load_en = 1'b0;
    step();
    chk("t6_np_valid", 64'(cfg_valid), 64'd1);
    chk("t6_np_data", 64'(cfg_data), 64'h1);
    chk("t6_np_err", 64'(frame_err), 64'd0);
    step();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
